stack_tracker: RTL
==================

# stack_tracker

Parametrised successor to the single-entry previous-block tracker in the block-stacker datapath. It holds the full stack of placed rows and computes the overlap of each dropped block against the top row itself. It trims the dropped block to that overlap and pushes the result. It flags game over on a miss and a win when the stack fills. It sits between the moving-block controller (source of `stop_true` and current coordinates) and the renderer/score logic (readers of the stack and status).

## Interface
- `X_W`, 9: coordinate width in pixels (start/end are inclusive pixel columns).
- `SIZE_W`, 4: block size width in cells.
- `UNIT_SHIFT`, 3: log2 of cell width in pixels; size = (end-start+1) >> UNIT_SHIFT.
- `DEPTH`, 12: maximum stacked rows; `LVL_W` = clog2(DEPTH+1) (derived).

- `clk` input 1: single clock, rising edge.
- `resetn` input 1: asynchronous, active-low reset.
- `stop_true` input 1: one-cycle drop request; accepted only in IDLE.
- `restart` input 1: synchronous clear of stack/status; priority over `stop_true`.
- `curr_block_start` input X_W: left edge of dropped block.
- `curr_block_end` input X_W: right edge of dropped block.
- `busy` output 1: high in any state other than IDLE.
- `result_valid` output 1: one-cycle pulse when a drop is resolved.
- `intersect_true` output 1: hit/miss of last drop; valid with and after `result_valid`.
- `prev_block_start`, `prev_block_end` output X_W: top-of-stack row (trimmed).
- `prev_block_size` output SIZE_W: top-of-stack size in cells.
- `stack_level` output LVL_W: number of rows stored.
- `game_over`, `win` output 1: sticky status flags.
- `rd_level` input LVL_W: renderer read index (0 = bottom).
- `rd_start`, `rd_end` output X_W: row at `rd_level`, combinational; 0 when `rd_level >= stack_level`.

## Operation
- States: IDLE, COMPARE, COMMIT, DONE.
- IDLE: on `stop_true`, latch `curr_block_start/end` and go to COMPARE.
- COMPARE: compute `ov_s = max(cs, top_s)` and `ov_e = min(ce, top_e)`. Hit if `ov_s <= ov_e`. If `stack_level == 0`, hit is unconditional and `ov = (cs, ce)`. If `cs > ce`, the drop is a miss.
- COMMIT on hit:
  - write `(ov_s, ov_e)` at index `stack_level`, then `stack_level += 1`;
  - `prev_*` take the trimmed row;
  - size = `(ov_e - ov_s + 1) >> UNIT_SHIFT`, computed at X_W+1 bits and saturated to 2^SIZE_W-1;
  - if the new level equals DEPTH, set `win` and go to DONE; else go to IDLE.
- COMMIT on miss:
  - no write;
  - `prev_block_start/end/size` clear to 0 (legacy miss behaviour);
  - set `game_over` and go to DONE.
- `intersect_true` is updated in COMMIT. `result_valid` pulses in COMMIT.
- DONE: ignore `stop_true`; hold all outputs.
- `restart` (any state): next edge clears all stack entries, `stack_level`, `prev_*`, `game_over`, `win`, `intersect_true`, and returns to IDLE. An in-flight drop is discarded with no `result_valid`.
- A trimmed size of 0 cells (overlap narrower than one cell) counts as a miss.

## Timing
- Reset (`resetn` low, async): state IDLE; every output 0, including all stack entries, `busy`, `result_valid`, flags and levels.
- `stop_true` sampled at edge T. COMPARE occupies T+1. COMMIT registers land at T+2: `result_valid`, `prev_*`, `stack_level` and flags are all visible after T+2 for one cycle (pulse).
- `busy` is high from after T through the COMMIT cycle. It stays high in DONE.
- Drop throughput is one per 3 cycles. `stop_true` while `busy` is dropped, not queued.
- `restart` and `stop_true` in the same IDLE cycle: `restart` wins.
- `resetn` deasserting mid-game is the same as a full clear.
- Read port: `rd_start`/`rd_end` reflect writes from the cycle after COMMIT.

## Test plan
- Base drop: reset; drop (100,163) -> after 2 cycles `result_valid`=1, `intersect_true`=1, prev=(100,163), size=8, level=1.
- Partial overlap: then drop (120,183) -> prev=(120,163), size=5, level=2; `rd_level`=0 reads (100,163).
- Miss: then drop (200,260) -> `intersect_true`=0, `game_over`=1, prev=(0,0,0), level stays 2. A further `stop_true` gives no `result_valid`.
- Sliver/invalid: top (120,163); drop (160,223) (overlap 4 px) -> miss. Drop with start 50, end 40 -> miss.
- Win: DEPTH=3; three identical drops (0,63) -> third sets `win`=1, level=3, busy stays high. `restart` -> all zero, IDLE.
- Priority/async: `restart` with `stop_true` in the same cycle -> no drop. `resetn` low mid-COMPARE -> outputs 0 immediately, no `result_valid`.

Source files
------------

// File: rtl/stack_tracker_if.sv
// Drop-request / stack-status bundle between the moving-block controller,
// the stack tracker and the renderer/score readers.
interface stack_tracker_if #(
    parameter int X_W    = 9,
    parameter int SIZE_W = 4,
    parameter int LVL_W  = 4
);
    logic              stop_true;
    logic              restart;
    logic [X_W-1:0]    curr_block_start;
    logic [X_W-1:0]    curr_block_end;
    logic              busy;
    logic              result_valid;
    logic              intersect_true;
    logic [X_W-1:0]    prev_block_start;
    logic [X_W-1:0]    prev_block_end;
    logic [SIZE_W-1:0] prev_block_size;
    logic [LVL_W-1:0]  stack_level;
    logic              game_over;
    logic              win;
    logic [LVL_W-1:0]  rd_level;
    logic [X_W-1:0]    rd_start;
    logic [X_W-1:0]    rd_end;

    modport slave (
        input  stop_true, restart, curr_block_start, curr_block_end, rd_level,
        output busy, result_valid, intersect_true, prev_block_start, prev_block_end,
               prev_block_size, stack_level, game_over, win, rd_start, rd_end
    );

    modport master (
        output stop_true, restart, curr_block_start, curr_block_end, rd_level,
        input  busy, result_valid, intersect_true, prev_block_start, prev_block_end,
               prev_block_size, stack_level, game_over, win, rd_start, rd_end
    );
endinterface

// File: rtl/stack_tracker.sv
// Block-stacker row stack: overlaps each dropped block with the top row,
// pushes the trimmed row on a hit, raises game_over on a miss and win when full.
module stack_tracker #(
    parameter int  X_W        = 9,
    parameter int  SIZE_W     = 4,
    parameter int  UNIT_SHIFT = 3,
    parameter int  DEPTH      = 12,
    localparam int LVL_W      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    stack_tracker_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COMPARE, COMMIT, DONE} state_e;

    localparam logic [X_W:0] SIZE_SAT = (X_W + 1)'((1 << SIZE_W) - 1);

    state_e            state_q, state_d;
    logic [X_W-1:0]    cs_q, cs_d, ce_q, ce_d;
    logic [X_W-1:0]    ov_s_q, ov_s_d, ov_e_q, ov_e_d;
    logic              hit_q, hit_d;
    logic [SIZE_W-1:0] sz_q, sz_d;
    logic [X_W-1:0]    stk_s_q [DEPTH];
    logic [X_W-1:0]    stk_s_d [DEPTH];
    logic [X_W-1:0]    stk_e_q [DEPTH];
    logic [X_W-1:0]    stk_e_d [DEPTH];
    logic [X_W-1:0]    prev_s_q, prev_s_d, prev_e_q, prev_e_d;
    logic [SIZE_W-1:0] prev_sz_q, prev_sz_d;
    logic [LVL_W-1:0]  lvl_q, lvl_d;
    logic              go_q, go_d, win_q, win_d, int_q, int_d, rv_q, rv_d;

    logic [X_W-1:0]    top_s, top_e, cmp_s, cmp_e, rd_s, rd_e;
    logic [X_W:0]      span, cells;
    logic              cmp_hit;
    logic [SIZE_W-1:0] cmp_sz;

    // Top row is the entry just below the write pointer.
    always_comb begin
        top_s = '0;
        top_e = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i + 1) == lvl_q) begin
                top_s = stk_s_q[i];
                top_e = stk_e_q[i];
            end
        end
    end

    // Overlap of the latched drop against the top row; an empty stack accepts the drop as-is.
    always_comb begin
        if (lvl_q == '0) begin
            cmp_s = cs_q;
            cmp_e = ce_q;
        end else begin
            cmp_s = (cs_q > top_s) ? cs_q : top_s;
            cmp_e = (ce_q < top_e) ? ce_q : top_e;
        end
        span    = {1'b0, cmp_e} - {1'b0, cmp_s} + (X_W + 1)'(1);
        cells   = span >> UNIT_SHIFT;
        cmp_hit = (cs_q <= ce_q) && (cmp_s <= cmp_e) && (cells != '0);
        cmp_sz  = (cells > SIZE_SAT) ? SIZE_SAT[SIZE_W-1:0] : cells[SIZE_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        ce_d      = ce_q;
        ov_s_d    = ov_s_q;
        ov_e_d    = ov_e_q;
        hit_d     = hit_q;
        sz_d      = sz_q;
        stk_s_d   = stk_s_q;
        stk_e_d   = stk_e_q;
        prev_s_d  = prev_s_q;
        prev_e_d  = prev_e_q;
        prev_sz_d = prev_sz_q;
        lvl_d     = lvl_q;
        go_d      = go_q;
        win_d     = win_q;
        int_d     = int_q;
        rv_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.stop_true) begin
                    cs_d    = bus.curr_block_start;
                    ce_d    = bus.curr_block_end;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                ov_s_d  = cmp_s;
                ov_e_d  = cmp_e;
                hit_d   = cmp_hit;
                sz_d    = cmp_sz;
                state_d = COMMIT;
            end
            COMMIT: begin
                rv_d  = 1'b1;
                int_d = hit_q;
                if (hit_q) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        if (LVL_W'(i) == lvl_q) begin
                            stk_s_d[i] = ov_s_q;
                            stk_e_d[i] = ov_e_q;
                        end
                    end
                    lvl_d     = lvl_q + LVL_W'(1);
                    prev_s_d  = ov_s_q;
                    prev_e_d  = ov_e_q;
                    prev_sz_d = sz_q;
                    if (lvl_q + LVL_W'(1) == LVL_W'(DEPTH)) begin
                        win_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    prev_s_d  = '0;
                    prev_e_d  = '0;
                    prev_sz_d = '0;
                    go_d      = 1'b1;
                    state_d   = DONE;
                end
            end
            default: ;
        endcase

        // Restart overrides everything, including a drop already in flight.
        if (bus.restart) begin
            state_d   = IDLE;
            cs_d      = '0;
            ce_d      = '0;
            ov_s_d    = '0;
            ov_e_d    = '0;
            hit_d     = 1'b0;
            sz_d      = '0;
            stk_s_d   = '{default: '0};
            stk_e_d   = '{default: '0};
            prev_s_d  = '0;
            prev_e_d  = '0;
            prev_sz_d = '0;
            lvl_d     = '0;
            go_d      = 1'b0;
            win_d     = 1'b0;
            int_d     = 1'b0;
            rv_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cs_q      <= '0;
            ce_q      <= '0;
            ov_s_q    <= '0;
            ov_e_q    <= '0;
            hit_q     <= 1'b0;
            sz_q      <= '0;
            stk_s_q   <= '{default: '0};
            stk_e_q   <= '{default: '0};
            prev_s_q  <= '0;
            prev_e_q  <= '0;
            prev_sz_q <= '0;
            lvl_q     <= '0;
            go_q      <= 1'b0;
            win_q     <= 1'b0;
            int_q     <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            ce_q      <= ce_d;
            ov_s_q    <= ov_s_d;
            ov_e_q    <= ov_e_d;
            hit_q     <= hit_d;
            sz_q      <= sz_d;
            stk_s_q   <= stk_s_d;
            stk_e_q   <= stk_e_d;
            prev_s_q  <= prev_s_d;
            prev_e_q  <= prev_e_d;
            prev_sz_q <= prev_sz_d;
            lvl_q     <= lvl_d;
            go_q      <= go_d;
            win_q     <= win_d;
            int_q     <= int_d;
            rv_q      <= rv_d;
        end
    end

    // Renderer read port: rows at or above the stack height read as zero.
    always_comb begin
        rd_s = '0;
        rd_e = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i) == bus.rd_level && LVL_W'(i) < lvl_q) begin
                rd_s = stk_s_q[i];
                rd_e = stk_e_q[i];
            end
        end
    end

    assign bus.busy             = (state_q != IDLE);
    assign bus.result_valid     = rv_q;
    assign bus.intersect_true   = int_q;
    assign bus.prev_block_start = prev_s_q;
    assign bus.prev_block_end   = prev_e_q;
    assign bus.prev_block_size  = prev_sz_q;
    assign bus.stack_level      = lvl_q;
    assign bus.game_over        = go_q;
    assign bus.win              = win_q;
    assign bus.rd_start         = rd_s;
    assign bus.rd_end           = rd_e;
endmodule
